// File: rtl/led_serial_capture.sv
// led_serial_capture: deserializes a 74HC595-style three-wire stream (data, shift clock, store clock) into a WIDTH-bit frame
//   iClk        system clock; it must be at least 2x faster than any phase of the serial clocks
//   iReset_n    synchronous active-low reset
//   iSerData    serial data, sampled on rising edges of iShiftClk
//   iShiftClk   each rising edge shifts one bit into the shift register
//   iStoreClk   each rising edge latches the shift register into oFrame
//   oFrame      last latched frame; the first bit shifted in ends up in bit 0
//   oFrameValid one-cycle pulse when oFrame updates
//   oBitCount   shift edges counted for the latched frame, saturating at WIDTH+1
//   oShortFrame latched frame had fewer than WIDTH shifts
//   oOverrun    latched frame had more than WIDTH shifts
//   oBusy       a frame is being shifted in (state is not IDLE)
module led_serial_capture #(
  parameter int WIDTH       = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       iClk,
  input  logic                       iReset_n,
  input  logic                       iSerData,
  input  logic                       iShiftClk,
  input  logic                       iStoreClk,
  output logic [WIDTH-1:0]           oFrame,
  output logic                       oFrameValid,
  output logic [$clog2(WIDTH)+1:0]   oBitCount,
  output logic                       oShortFrame,
  output logic                       oOverrun,
  output logic                       oBusy
);
  localparam int CW = $clog2(WIDTH) + 2;
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] MAX  = CW'(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, OVER} state_t;
  logic [SYNC_STAGES-1:0] r_data_sync, r_shift_sync, r_store_sync, r_settle;
  logic                   r_shift_prev, r_store_prev, r_shift_armed, r_store_armed;
  logic [WIDTH-1:0]       r_sr;
  logic [CW-1:0]          r_count;
  state_t                 r_state, w_next;
  logic                   w_data, w_shift, w_store, w_valid, w_shift_edge, w_store_edge;
  // Data runs through the same number of stages as the clocks so it stays aligned with its shift edge.
  assign w_data  = r_data_sync[SYNC_STAGES-1];
  assign w_shift = r_shift_sync[SYNC_STAGES-1];
  assign w_store = r_store_sync[SYNC_STAGES-1];
  // r_settle marks when the synchronizer outputs hold real samples instead of reset zeros.
  // A clock is armed only after it has been seen low, so a line already high at reset release gives no edge.
  assign w_valid      = r_settle[SYNC_STAGES-1];
  assign w_shift_edge = w_shift & ~r_shift_prev & r_shift_armed;
  assign w_store_edge = w_store & ~r_store_prev & r_store_armed;
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      r_data_sync   <= '0;
      r_shift_sync  <= '0;
      r_store_sync  <= '0;
      r_settle      <= '0;
      r_shift_prev  <= 1'b0;
      r_store_prev  <= 1'b0;
      r_shift_armed <= 1'b0;
      r_store_armed <= 1'b0;
    end else begin
      r_data_sync   <= {r_data_sync[SYNC_STAGES-2:0], iSerData};
      r_shift_sync  <= {r_shift_sync[SYNC_STAGES-2:0], iShiftClk};
      r_store_sync  <= {r_store_sync[SYNC_STAGES-2:0], iStoreClk};
      r_settle      <= {r_settle[SYNC_STAGES-2:0], 1'b1};
      r_shift_prev  <= w_shift;
      r_store_prev  <= w_store;
      r_shift_armed <= r_shift_armed | (w_valid & ~w_shift);
      r_store_armed <= r_store_armed | (w_valid & ~w_store);
    end
  end
  // Store reads r_sr and r_count before any same-cycle shift updates them (tied-clock behaviour).
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      r_sr        <= '0;
      r_count     <= '0;
      oFrame      <= '0;
      oFrameValid <= 1'b0;
      oBitCount   <= '0;
      oShortFrame <= 1'b0;
      oOverrun    <= 1'b0;
    end else begin
      oFrameValid <= w_store_edge;
      if (w_shift_edge)
        r_sr <= {w_data, r_sr[WIDTH-1:1]};
      if (w_store_edge)
        r_count <= w_shift_edge ? CW'(1) : '0;
      else if (w_shift_edge && r_count != MAX)
        r_count <= r_count + 1'b1;
      if (w_store_edge) begin
        oFrame      <= r_sr;
        oBitCount   <= r_count;
        oShortFrame <= r_count < FULL;
        oOverrun    <= r_count > FULL;
      end
    end
  end
  always_ff @(posedge iClk) begin
    if (!iReset_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (w_store_edge)
      w_next = w_shift_edge ? SHIFT : IDLE;
    else if (w_shift_edge)
      w_next = (r_state == IDLE) ? SHIFT : (r_state == SHIFT && r_count == FULL) ? OVER : r_state;
  end
  always_comb begin
    oBusy = r_state != IDLE;
  end
endmodule

// File: tb/tb_led_serial_capture.sv
// tb_led_serial_capture: randomized stimulus against a history-queue reference model of the serial capture
module tb_led_serial_capture;
  localparam int W  = 256;
  localparam int S  = 2;
  localparam int CW = $clog2(W) + 2;
  logic          iClk = 1'b0, iReset_n = 1'b0, iSerData = 1'b0, iShiftClk = 1'b0, iStoreClk = 1'b0;
  logic [W-1:0]  oFrame;
  logic          oFrameValid, oShortFrame, oOverrun, oBusy;
  logic [CW-1:0] oBitCount;
  int            checks = 0, errors = 0, pulses = 0, cnt = 0;
  bit            hist[$];
  led_serial_capture #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iSerData(iSerData), .iShiftClk(iShiftClk),
    .iStoreClk(iStoreClk), .oFrame(oFrame), .oFrameValid(oFrameValid), .oBitCount(oBitCount),
    .oShortFrame(oShortFrame), .oOverrun(oOverrun), .oBusy(oBusy)
  );
  always #5 iClk = ~iClk;
  always @(negedge iClk) if (oFrameValid === 1'b1) pulses++;
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Shift register content = the last W bits received since reset, oldest in bit 0, zeros where nothing arrived.
  function automatic logic [W-1:0] model_frame();
    logic [W-1:0] f = '0;
    int n = hist.size();
    for (int k = 0; k < W; k++) begin
      int idx = n - W + k;
      if (idx >= 0) f[k] = hist[idx];
    end
    return f;
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask
  task automatic send_bit(input bit b);
    iSerData = b;
    tick($urandom_range(2, 3));
    iShiftClk = 1'b1;
    tick($urandom_range(2, 3));
    iShiftClk = 1'b0;
    hist.push_back(b);
    cnt++;
  endtask
  task automatic do_reset(input int n);
    iReset_n = 1'b0;
    tick(n);
    iReset_n = 1'b1;
    hist.delete();
    cnt = 0;
    tick(S + 2);
  endtask
  task automatic store_frame(input string tag, input bit also_shift, input bit b);
    logic [W-1:0] ef = model_frame();
    int ec = (cnt > W + 1) ? W + 1 : cnt;
    int lat = 0;
    int p0;
    if (also_shift) begin
      iSerData = b;
      tick(2);
    end
    p0 = pulses;
    iStoreClk = 1'b1;
    iShiftClk = also_shift;
    for (int k = 1; k <= S + 8 && lat == 0; k++) begin
      tick(1);
      if (oFrameValid === 1'b1) lat = k;
    end
    check({tag, "_lat"}, lat, S + 1);
    check({tag, "_frame"}, oFrame, ef);
    check({tag, "_count"}, oBitCount, ec);
    check({tag, "_short"}, oShortFrame, ec < W);
    check({tag, "_over"}, oOverrun, ec > W);
    check({tag, "_busy"}, oBusy, also_shift);
    tick(1);
    check({tag, "_vlow"}, oFrameValid, 0);
    if (also_shift) begin
      hist.push_back(b);
      cnt = 1;
    end else cnt = 0;
    tick(2);
    iStoreClk = 1'b0;
    iShiftClk = 1'b0;
    tick(3);
    check({tag, "_pulses"}, pulses - p0, 1);
  endtask
  initial begin
    logic [7:0] a5 = 8'hA5;
    iShiftClk = 1'b1;
    iStoreClk = 1'b1;
    tick(3);
    iReset_n = 1'b1;
    tick(10);
    check("rst_pulses", pulses, 0);
    check("rst_frame", oFrame, 0);
    check("rst_count", oBitCount, 0);
    check("rst_short", oShortFrame, 0);
    check("rst_over", oOverrun, 0);
    check("rst_busy", oBusy, 0);
    iShiftClk = 1'b0;
    iStoreClk = 1'b0;
    tick(S + 2);
    for (int i = 0; i < W; i++) send_bit(i % 3 == 0);
    check("mod3_busy", oBusy, 1);
    store_frame("mod3", 1'b0, 1'b0);
    check("mod3_b0", oFrame[0], 1);
    check("mod3_b1", oFrame[1], 0);
    check("mod3_b255", oFrame[255], 1);
    do_reset(1);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    store_frame("short", 1'b0, 1'b0);
    check("short_top", oFrame[255:246], 10'h3FF);
    for (int i = 0; i < 300; i++) send_bit(1'($urandom));
    store_frame("over", 1'b0, 1'b0);
    for (int i = 0; i < W; i++) send_bit(1'($urandom));
    store_frame("tied", 1'b1, 1'($urandom));
    store_frame("after_tied", 1'b0, 1'b0);
    for (int i = 0; i < 128; i++) send_bit(1'($urandom));
    do_reset(1);
    check("midrst_frame", oFrame, 0);
    check("midrst_busy", oBusy, 0);
    for (int i = 0; i < W; i++) send_bit(a5[i % 8]);
    store_frame("a5", 1'b0, 1'b0);
    check("a5_pattern", oFrame, {32{8'hA5}});
    store_frame("empty", 1'b0, 1'b0);
    for (int f = 0; f < 5; f++) begin
      int len = $urandom_range(0, 300);
      for (int i = 0; i < len; i++) send_bit(1'($urandom));
      store_frame("rand", 1'b0, 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_serial_capture.md
Name: led_serial_capture

Overview:
- Receive-side counterpart of the LED-matrix serial driver. Deserializes the three-wire shift-register stream (serial data, shift clock, store clock) back into a WIDTH-bit parallel frame, behaving like a chain of 74HC595-style registers.
- Used as an on-board loopback checker for the matrix driver and as a frame input for a second board or display model.
- All three serial inputs are treated as asynchronous to iClk and are oversampled by iClk.

Parameters:
- WIDTH, 256, bits per frame (matrix pixels).
- SYNC_STAGES, 2, synchronizer flops per serial input (legal range 2..4).

Ports:
- iClk  input  1  system clock. Must be at least 2x faster than any high or low phase of iShiftClk or iStoreClk.
- iReset_n  input  1  synchronous active-low reset.
- iSerData  input  1  serial data, valid at the rising edge of iShiftClk.
- iShiftClk  input  1  shift clock. Each rising edge shifts in one bit.
- iStoreClk  input  1  store clock. Each rising edge latches the shift register into oFrame.
- oFrame  output  WIDTH  last latched frame. The first bit shifted in lands in bit 0.
- oFrameValid  output  1  one-cycle pulse when oFrame updates.
- oBitCount  output  clog2(WIDTH)+2  number of shift edges counted for the latched frame, saturating at WIDTH+1.
- oShortFrame  output  1  the latched frame had fewer than WIDTH shifts.
- oOverrun  output  1  the latched frame had more than WIDTH shifts.
- oBusy  output  1  state is not IDLE.

Behaviour:
- Interface: reset iReset_n, synchronous, active-low; clock iClk.
- Synchronization
  - iSerData, iShiftClk and iStoreClk each pass through SYNC_STAGES flops, so data stays aligned with the shift clock.
  - A previous-value flop follows each synchronized clock. An edge is detected when the synchronized value is 1 and the previous value is 0.
  - Only rising edges act.
- Shift register
  - On a shift edge: sr <= {data_sync, sr[WIDTH-1:1]}.
  - After exactly WIDTH shifts, the first bit received is at sr[0].
- Bit counter
  - Increments on each shift edge and saturates at WIDTH+1.
  - Cleared on a store edge; a simultaneous shift edge then counts as the first bit of the next frame.
- FSM states and transitions
  - IDLE: count=0.
  - SHIFT: 1 <= count <= WIDTH.
  - OVER: count = WIDTH+1.
  - IDLE->SHIFT on a shift edge.
  - SHIFT->OVER on a shift edge when count=WIDTH.
  - Any state -> IDLE on a store edge, or -> SHIFT if a shift edge occurs in the same cycle.
- Store edge actions (all registered on the same iClk edge)
  - oFrame <= sr as it was before any same-cycle shift (74HC595 tied-clock semantics).
  - oBitCount <= count.
  - oShortFrame <= (count < WIDTH).
  - oOverrun <= (count > WIDTH).
  - oFrameValid <= 1 for exactly one cycle.
- Store behaviour at boundaries
  - A store edge with count=0 still latches: oFrame = current sr, oShortFrame=1, oBitCount=0.
  - Flags and oBitCount hold until the next store edge.
- Latency: an iStoreClk rising transition first sampled high at iClk edge N gives oFrameValid high after edge N+SYNC_STAGES, low after edge N+SYNC_STAGES+1. iShiftClk has the same latency.
- Reset
  - Clears sr, count, all synchronizer and previous-value flops, oFrame, oFrameValid, oBitCount, oShortFrame and oOverrun to 0.
  - State goes to IDLE, so oBusy=0.
  - A serial input that is already high at reset release produces no edge.
  - Reset mid-frame discards the partial frame; oFrame is not updated.
- Sampling rule: input phases shorter than 2 iClk periods are undefined behaviour. No glitch filtering beyond synchronization.

Test Plan:
- Reset hold 3 cycles, then release with iShiftClk=1 and iStoreClk=1 -> no oFrameValid pulse; all outputs 0; oBusy=0.
- 256 shifts of bit i = (i mod 3 == 0), then store edge -> oFrameValid pulses once, SYNC_STAGES cycles after store is sampled. oFrame[0]=1, oFrame[1]=0, oFrame[255]=1; oBitCount=256; both flags 0.
- 10 shifts of 1, then store -> oShortFrame=1, oBitCount=10, oFrame[255:246]=all 1, oFrame[245:0]=0 after reset.
- 300 shifts, then store -> oOverrun=1, oBitCount=257, oFrame holds the last 256 bits received.
- Full 256-bit frame, then a final shift edge and store edge arriving on the same iClk sample -> oFrame equals the pre-shift sr; the new count is 1; state is SHIFT.
- 128 shifts, then iReset_n low for 1 cycle, then a full 256-bit frame of 0xA5 bytes and store -> oFrame equals the new 0xA5 pattern only; exactly one oFrameValid pulse.
